xintf_bus_master: RTL and testbench

Initiator side of the DSP XINTF external-memory bus. It drives chip-select, write/read strobes, address and data toward an XINTF slave, such as the FPGA-side DPBRAM mux or a second FPGA. Strobe timing comes from lead/active/trail phase counts. Internal logic sends single-beat read or write requests over a valid/ready handshake and gets back a one-cycle response pulse carrying read data.

---
 rtl/xintf_pkg.sv | 29 ++
 rtl/xintf_phase_timer.sv | 38 +++
 rtl/xintf_bus_master.sv | 150 +++++++++++++++
 tb/tb_xintf_bus_master.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/xintf_pkg.sv
// -----------------------------------------------------------------------------
// xintf_pkg
// Shared definitions for the XINTF bus initiator:
//   - xintf_state_e : bus-cycle FSM states (IDLE / LEAD / ACTIVE / TRAIL)
//   - XINTF_ADDR_W  : default XINTF address width
//   - XINTF_DATA_W  : default XINTF data width
//   - PHASE_W       : width of the phase counter (dwell of 1..15 cycles)
//   - phase_load()  : converts a dwell in cycles into the counter load value
// -----------------------------------------------------------------------------
package xintf_pkg;

  localparam int XINTF_ADDR_W = 9;
  localparam int XINTF_DATA_W = 16;
  localparam int PHASE_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LEAD   = 2'd1,
    ST_ACTIVE = 2'd2,
    ST_TRAIL  = 2'd3
  } xintf_state_e;

  // The counter counts down to zero inclusive, so a dwell of N cycles
  // loads N-1.
  function automatic logic [PHASE_W-1:0] phase_load(input int cycles);
    return PHASE_W'(cycles - 1);
  endfunction

endpackage

// File: rtl/xintf_phase_timer.sv
// -----------------------------------------------------------------------------
// xintf_phase_timer
// Loadable down-counter with a zero flag. The FSM reloads it on every state
// entry; zero marks the last cycle of the current phase.
// Ports:
//   i_clk      : clock, rising edge
//   i_rst      : asynchronous active-low reset (counter clears to 0)
//   i_load     : load i_load_val on this edge (takes priority over counting)
//   i_load_val : value to load
//   o_zero     : counter is 0
// -----------------------------------------------------------------------------
module xintf_phase_timer
  import xintf_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_load,
  input  logic [PHASE_W-1:0] i_load_val,
  output logic               o_zero
);

  logic [PHASE_W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      count <= '0;
    end else if (i_load) begin
      count <= i_load_val;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign o_zero = (count == '0);

endmodule

// File: rtl/xintf_bus_master.sv
// -----------------------------------------------------------------------------
// xintf_bus_master
// Initiator side of the DSP XINTF external-memory bus. A single-beat read or
// write request accepted over valid/ready becomes one bus cycle made of LEAD,
// ACTIVE and TRAIL phases; completion is a one-cycle o_rsp_valid pulse that
// also carries read data.
// Ports:
//   i_clk, i_rst        : clock (rising edge), async active-low reset
//   i_req_valid/o_req_ready, i_req_wr, i_req_addr, i_req_wdata : request
//   o_rsp_valid, o_rsp_rdata                                   : response
//   o_nZ_B_CS, o_nZ_B_WE, o_nZ_B_RD : active-low bus strobes (registered)
//   o_Z_B_XA                        : bus address (registered)
//   io_Z_B_XD                       : bus data, driven only in write cycles
//   o_busy                          : any state other than IDLE
// -----------------------------------------------------------------------------
module xintf_bus_master
  import xintf_pkg::*;
#(
  parameter int ADDR_W = XINTF_ADDR_W,
  parameter int DATA_W = XINTF_DATA_W,
  parameter int LEAD   = 2,
  parameter int ACTIVE = 5,
  parameter int TRAIL  = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_wr,
  input  logic [ADDR_W-1:0] i_req_addr,
  input  logic [DATA_W-1:0] i_req_wdata,
  output logic              o_rsp_valid,
  output logic [DATA_W-1:0] o_rsp_rdata,
  output logic              o_nZ_B_CS,
  output logic              o_nZ_B_WE,
  output logic              o_nZ_B_RD,
  output logic [ADDR_W-1:0] o_Z_B_XA,
  inout  wire  [DATA_W-1:0] io_Z_B_XD,
  output logic              o_busy
);

  localparam int PHASE_MAX = (1 << PHASE_W) - 1;

  // Phase dwells must fit the counter and be at least one cycle.
  if (LEAD < 1 || LEAD > PHASE_MAX || ACTIVE < 1 || ACTIVE > PHASE_MAX ||
      TRAIL < 1 || TRAIL > PHASE_MAX) begin : g_bad_phase
    $error("xintf_bus_master: LEAD/ACTIVE/TRAIL must be within 1..%0d", PHASE_MAX);
  end

  xintf_state_e       state_q, state_d;
  logic               timer_load;
  logic [PHASE_W-1:0] timer_val;
  logic               timer_zero;
  logic               accept;
  logic               wr_q, wr_d;
  logic [DATA_W-1:0]  wdata_q;
  logic               cs_n_d, we_n_d, rd_n_d, oe_d;
  logic               oe_q;

  xintf_phase_timer u_timer (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_load     (timer_load),
    .i_load_val (timer_val),
    .o_zero     (timer_zero)
  );

  // NOTE: every signal written here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    accept     = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (i_req_valid) begin
          accept     = 1'b1;
          state_d    = ST_LEAD;
          timer_load = 1'b1;
          timer_val  = phase_load(LEAD);
        end
      end
      ST_LEAD: begin
        if (timer_zero) begin
          state_d    = ST_ACTIVE;
          timer_load = 1'b1;
          timer_val  = phase_load(ACTIVE);
        end
      end
      ST_ACTIVE: begin
        if (timer_zero) begin
          state_d    = ST_TRAIL;
          timer_load = 1'b1;
          timer_val  = phase_load(TRAIL);
        end
      end
      ST_TRAIL: begin
        if (timer_zero) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Pin values are decoded from the next state and registered, so the bus
    // pins change on the same edge as the state and never see the request
    // inputs combinationally.
    wr_d   = accept ? i_req_wr : wr_q;
    cs_n_d = (state_d == ST_IDLE);
    we_n_d = !((state_d == ST_ACTIVE) && wr_d);
    rd_n_d = !((state_d == ST_ACTIVE) && !wr_d);
    oe_d   = (state_d != ST_IDLE) && wr_d;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= ST_IDLE;
      wr_q        <= 1'b0;
      wdata_q     <= '0;
      o_Z_B_XA    <= '0;
      o_nZ_B_CS   <= 1'b1;
      o_nZ_B_WE   <= 1'b1;
      o_nZ_B_RD   <= 1'b1;
      oe_q        <= 1'b0;
      o_rsp_valid <= 1'b0;
      o_rsp_rdata <= '0;
    end else begin
      state_q   <= state_d;
      wr_q      <= wr_d;
      o_nZ_B_CS <= cs_n_d;
      o_nZ_B_WE <= we_n_d;
      o_nZ_B_RD <= rd_n_d;
      oe_q      <= oe_d;
      if (accept) begin
        wdata_q  <= i_req_wdata;
        o_Z_B_XA <= i_req_addr;
      end
      // Completion pulse lands in the IDLE cycle that follows TRAIL.
      o_rsp_valid <= (state_q == ST_TRAIL) && timer_zero;
      // Read data is sampled on the edge that ends the final ACTIVE cycle.
      if ((state_q == ST_ACTIVE) && timer_zero && !wr_q) begin
        o_rsp_rdata <= io_Z_B_XD;
      end
    end
  end

  assign io_Z_B_XD   = oe_q ? wdata_q : {DATA_W{1'bz}};
  assign o_req_ready = (state_q == ST_IDLE);
  assign o_busy      = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xintf_bus_master.sv
// -----------------------------------------------------------------------------
// tb_xintf_bus_master
// Directed bench for xintf_bus_master. Instance A uses the default phases
// (2/5/1) and talks to a DPBRAM-mux-like slave model; instance B uses 1/1/1.
// Outputs are sampled on the falling clock edge; inputs change there too.
// -----------------------------------------------------------------------------
module tb_xintf_bus_master;

  localparam int AW = 9;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // ---------------- instance A (default phases) ----------------
  logic          a_valid, a_wr;
  logic [AW-1:0] a_addr;
  logic [DW-1:0] a_wdata;
  logic          a_ready, a_rsp_valid, a_cs_n, a_we_n, a_rd_n, a_busy;
  logic [DW-1:0] a_rdata;
  logic [AW-1:0] a_xa;
  wire  [DW-1:0] a_xd;

  xintf_bus_master dut_a (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (a_valid),
    .o_req_ready (a_ready),
    .i_req_wr    (a_wr),
    .i_req_addr  (a_addr),
    .i_req_wdata (a_wdata),
    .o_rsp_valid (a_rsp_valid),
    .o_rsp_rdata (a_rdata),
    .o_nZ_B_CS   (a_cs_n),
    .o_nZ_B_WE   (a_we_n),
    .o_nZ_B_RD   (a_rd_n),
    .o_Z_B_XA    (a_xa),
    .io_Z_B_XD   (a_xd),
    .o_busy      (a_busy)
  );

  // Slave model: captures writes while nCS/nWE are low, drives read data
  // while nCS/nRD are low and nWE is high.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic          preload_en = 1'b0;
  logic [AW-1:0] preload_addr = '0;
  logic [DW-1:0] preload_data = '0;

  always @(posedge clk) begin
    if (preload_en) mem[preload_addr] <= preload_data;
    else if (!a_cs_n && !a_we_n) mem[a_xa] <= a_xd;
  end

  assign a_xd = (!a_cs_n && a_we_n && !a_rd_n) ? mem[a_xa] : {DW{1'bz}};

  // ---------------- instance B (1/1/1 phases) ----------------
  logic          b_valid, b_wr;
  logic [AW-1:0] b_addr;
  logic [DW-1:0] b_wdata;
  logic          b_ready, b_rsp_valid, b_cs_n, b_we_n, b_rd_n, b_busy;
  logic [DW-1:0] b_rdata;
  logic [AW-1:0] b_xa;
  wire  [DW-1:0] b_xd;

  xintf_bus_master #(.LEAD(1), .ACTIVE(1), .TRAIL(1)) dut_b (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_req_valid (b_valid),
    .o_req_ready (b_ready),
    .i_req_wr    (b_wr),
    .i_req_addr  (b_addr),
    .i_req_wdata (b_wdata),
    .o_rsp_valid (b_rsp_valid),
    .o_rsp_rdata (b_rdata),
    .o_nZ_B_CS   (b_cs_n),
    .o_nZ_B_WE   (b_we_n),
    .o_nZ_B_RD   (b_rd_n),
    .o_Z_B_XA    (b_xa),
    .io_Z_B_XD   (b_xd),
    .o_busy      (b_busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One transaction on instance A, called just after a falling edge.
  // Cycle n is the n-th cycle after the accept edge; with 2/5/1 phases
  // nCS is low in n=1..8, the strobe in n=3..7 and o_rsp_valid in n=9.
  // hold keeps i_req_valid high; next_at raises a new request in cycle n.
  task automatic do_txn(input string tag, input logic wr, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, input logic [DW-1:0] exp_rdata,
                        input logic hold, input int next_at, input logic next_wr,
                        input logic [AW-1:0] next_addr);
    logic [5:0] exp_ctl;
    logic       bus, strobe;
    a_valid = 1'b1;
    a_wr    = wr;
    a_addr  = addr;
    a_wdata = wdata;
    check({tag, ".ready"}, 32'(a_ready), 32'd1);
    check({tag, ".idle_cs"}, 32'(a_cs_n), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (n == 1 && !hold) a_valid = 1'b0;
      if (n == next_at) begin
        a_valid = 1'b1;
        a_wr    = next_wr;
        a_addr  = next_addr;
      end
      bus     = (n <= 8);
      strobe  = (n >= 3 && n <= 7);
      // {nCS, nWE, nRD, rsp_valid, ready, busy}
      exp_ctl = {!bus, !(strobe && wr), !(strobe && !wr), n == 9, n == 9, bus};
      check($sformatf("%s.c%0d.ctl", tag, n),
            32'({a_cs_n, a_we_n, a_rd_n, a_rsp_valid, a_ready, a_busy}), 32'(exp_ctl));
      if (bus) check($sformatf("%s.c%0d.xa", tag, n), 32'(a_xa), 32'(addr));
      if (bus && wr) check($sformatf("%s.c%0d.xd", tag, n), 32'(a_xd), 32'(wdata));
      if (n == 7 && !wr) check($sformatf("%s.c7.slave_xd", tag), 32'(a_xd), 32'(exp_rdata));
    end
    if (!wr) check({tag, ".rdata"}, 32'(a_rdata), 32'(exp_rdata));
  endtask

  initial begin
    logic seen_rsp;
    a_valid = 1'b0; a_wr = 1'b0; a_addr = '0; a_wdata = '0;
    b_valid = 1'b0; b_wr = 1'b0; b_addr = '0; b_wdata = '0;

    // ---- reset state and slave preload ----
    repeat (2) @(negedge clk);
    check("rst.a_ctl", 32'({a_cs_n, a_we_n, a_rd_n, a_rsp_valid, a_ready, a_busy}), 32'b111010);
    check("rst.a_xa", 32'(a_xa), 32'd0);
    check("rst.a_rdata", 32'(a_rdata), 32'd0);
    check("rst.b_ctl", 32'({b_cs_n, b_we_n, b_rd_n, b_rsp_valid, b_ready, b_busy}), 32'b111010);
    preload_en = 1'b1; preload_addr = 9'h003; preload_data = 16'h1234;
    @(negedge clk);
    preload_en = 1'b0;
    rst = 1'b1;
    @(negedge clk);

    // ---- single write and single read ----
    do_txn("wr1a5", 1'b1, 9'h1A5, 16'hBEEF, 16'h0000, 1'b0, 0, 1'b0, '0);
    @(negedge clk);
    do_txn("rd003", 1'b0, 9'h003, 16'h0000, 16'h1234, 1'b0, 0, 1'b0, '0);
    @(negedge clk);

    // ---- back-to-back with valid held: one nCS-high cycle in between ----
    do_txn("b2b_wr", 1'b1, 9'h010, 16'h5555, 16'h0000, 1'b1, 0, 1'b0, '0);
    do_txn("b2b_rd", 1'b0, 9'h010, 16'h0000, 16'h5555, 1'b0, 0, 1'b0, '0);
    @(negedge clk);

    // ---- request raised while busy: taken only after the first completes ----
    do_txn("busy_wr", 1'b1, 9'h0AA, 16'hA5A5, 16'h0000, 1'b0, 2, 1'b0, 9'h010);
    do_txn("busy_rd", 1'b0, 9'h010, 16'h0000, 16'h5555, 1'b0, 0, 1'b0, '0);
    @(negedge clk);

    // ---- reset in ACTIVE cycle 3 of a write ----
    a_valid = 1'b1; a_wr = 1'b1; a_addr = 9'h0F0; a_wdata = 16'h1357;
    @(posedge clk);
    for (int n = 1; n <= 5; n++) begin
      @(negedge clk);
      if (n == 1) a_valid = 1'b0;
    end
    check("midrst.pre_we", 32'({a_cs_n, a_we_n}), 32'b00);
    rst = 1'b0;
    #1;
    check("midrst.ctl", 32'({a_cs_n, a_we_n, a_rd_n, a_rsp_valid, a_ready, a_busy}), 32'b111010);
    check("midrst.xa", 32'(a_xa), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    seen_rsp = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (a_rsp_valid || !a_cs_n) seen_rsp = 1'b1;
    end
    check("midrst.no_rsp", 32'(seen_rsp), 32'd0);
    do_txn("postrst_rd", 1'b0, 9'h003, 16'h0000, 16'h1234, 1'b0, 0, 1'b0, '0);
    @(negedge clk);

    // ---- 1/1/1 phases: period 4, strobe centred in 3-cycle nCS window ----
    b_valid = 1'b1; b_wr = 1'b1; b_addr = 9'h055; b_wdata = 16'h00FF;
    check("p111.ready", 32'(b_ready), 32'd1);
    @(posedge clk);
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      // {nCS, nWE, nRD, rsp_valid}
      check($sformatf("p111.c%0d", n), 32'({b_cs_n, b_we_n, b_rd_n, b_rsp_valid}),
            32'({(n % 4) == 0, (n % 4) != 2, 1'b1, (n % 4) == 0}));
      if ((n % 4) != 0) check($sformatf("p111.c%0d.xd", n), 32'(b_xd), 32'h00FF);
    end
    b_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("p111.idle", 32'({b_cs_n, b_busy, b_ready}), 32'b101);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
